// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths, arbiter state encoding and header type for matrix storage access.
package matrix_pkg;
    localparam int MATRIX_ID_W = 3;
    localparam int DIM_W = 8;
    localparam int NAME_BYTES = 8;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WRITE,
        STREAM,
        ISSUE_CLEAR,
        WAIT_CLEAR,
        RELEASE
    } arb_state_t;

    typedef struct packed {
        logic [MATRIX_ID_W-1:0] id;
        logic [DIM_W-1:0] rows;
        logic [DIM_W-1:0] cols;
        logic [NAME_BYTES*8-1:0] name;
    } matrix_hdr_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first set request at or after the pointer, searching upward with wrap.
module rr_priority_select #(
    parameter int N = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_winner,
    output logic [IW-1:0] o_index,
    output logic          o_any
);
    logic [IW-1:0] w_j;

    // Scan from the farthest offset down so the nearest request to the pointer wins last.
    always_comb begin
        w_j = '0;
        o_index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_rr_ptr) + k) % N);
            if (i_req[w_j]) o_index = w_j;
        end
    end

    assign o_any = |i_req;
    assign o_winner = o_any ? N'(1) << o_index : '0;
endmodule

// File: rtl/matrix_storage_arbiter.sv
// matrix_storage_arbiter: round-robin owner of the storage manager write/clear port,
// holding each grant for a whole transaction with a stall watchdog.
module matrix_storage_arbiter
    import matrix_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_is_clear,
    input  logic [NUM_REQ-1:0][MATRIX_ID_W-1:0]   req_matrix_id,
    input  logic [NUM_REQ-1:0][DIM_W-1:0]         req_rows,
    input  logic [NUM_REQ-1:0][DIM_W-1:0]         req_cols,
    input  logic [NUM_REQ-1:0][NAME_BYTES*8-1:0]  req_name,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]        req_data,
    input  logic [NUM_REQ-1:0]                    req_data_valid,
    output logic [NUM_REQ-1:0]                    grant,
    output logic [NUM_REQ-1:0]                    req_writer_ready,
    output logic [NUM_REQ-1:0]                    req_done,
    output logic [NUM_REQ-1:0]                    req_error,
    output logic                                  write_request,
    input  logic                                  write_ready,
    output logic [MATRIX_ID_W-1:0]                matrix_id,
    output logic [DIM_W-1:0]                      actual_rows,
    output logic [DIM_W-1:0]                      actual_cols,
    output logic [NAME_BYTES*8-1:0]               matrix_name,
    output logic [DATA_W-1:0]                     data_in,
    output logic                                  data_valid,
    input  logic                                  write_done,
    input  logic                                  writer_ready,
    output logic                                  clear_request,
    input  logic                                  clear_done,
    output logic [MATRIX_ID_W-1:0]                clear_matrix_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t    r_state;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_rr_ptr;
    matrix_hdr_t   r_hdr;
    logic [15:0]   r_wd;

    logic [NUM_REQ-1:0] w_winner;
    logic [IW-1:0]      w_index;
    logic               w_any;
    logic               w_progress;
    logic               w_expired;

    rr_priority_select #(.N(NUM_REQ), .IW(IW)) u_sel (
        .i_req   (req_valid),
        .i_rr_ptr(r_rr_ptr),
        .o_winner(w_winner),
        .o_index (w_index),
        .o_any   (w_any)
    );

    assign write_request    = r_state == ISSUE_WRITE && write_ready;
    assign data_valid       = r_state == STREAM && req_data_valid[r_owner];
    assign data_in          = r_state == STREAM ? req_data[r_owner] : '0;
    assign req_writer_ready = (r_state == STREAM && writer_ready) ? grant : '0;
    assign matrix_id        = r_hdr.id;
    assign clear_matrix_id  = r_hdr.id;
    assign actual_rows      = r_hdr.rows;
    assign actual_cols      = r_hdr.cols;
    assign matrix_name      = r_hdr.name;

    assign w_progress = data_valid || write_ready || writer_ready;
    assign w_expired  = !w_progress && r_wd == WD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_hdr         <= '0;
            r_wd          <= '0;
            grant         <= '0;
            req_done      <= '0;
            req_error     <= '0;
            clear_request <= '0;
        end else begin
            req_done      <= '0;
            req_error     <= '0;
            clear_request <= '0;
            // Counter only runs in the waiting states; every other state re-arms it for the next entry.
            r_wd <= (w_progress || !(r_state inside {ISSUE_WRITE, STREAM, WAIT_CLEAR})) ? '0 : r_wd + 16'd1;
            case (r_state)
                IDLE: if (w_any) begin
                    r_owner <= w_index;
                    grant   <= w_winner;
                    r_hdr   <= '{id: req_matrix_id[w_index], rows: req_rows[w_index],
                                 cols: req_cols[w_index], name: req_name[w_index]};
                    r_state <= req_is_clear[w_index] ? ISSUE_CLEAR : ISSUE_WRITE;
                end
                ISSUE_WRITE: if (write_ready) r_state <= STREAM;
                    else if (w_expired) begin
                        req_error <= grant;
                        r_state   <= RELEASE;
                    end
                STREAM: if (write_done) begin
                        req_done <= grant;
                        r_state  <= RELEASE;
                    end else if (w_expired) begin
                        req_error <= grant;
                        r_state   <= RELEASE;
                    end
                ISSUE_CLEAR: begin
                    clear_request <= 1'b1;
                    r_state       <= WAIT_CLEAR;
                end
                WAIT_CLEAR: if (clear_done) begin
                        req_done <= grant;
                        r_state  <= RELEASE;
                    end else if (w_expired) begin
                        req_error <= grant;
                        r_state   <= RELEASE;
                    end
                RELEASE: begin
                    grant    <= '0;
                    r_rr_ptr <= r_owner == IW'(NUM_REQ - 1) ? '0 : r_owner + IW'(1);
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_storage_arbiter.sv
// tb_matrix_storage_arbiter: directed checks of grant order, write/clear flows, watchdog and reset.
module tb_matrix_storage_arbiter;
    import matrix_pkg::*;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0, req_is_clear = '0, req_data_valid = '0;
    logic [N-1:0][MATRIX_ID_W-1:0] req_matrix_id = '0;
    logic [N-1:0][DIM_W-1:0] req_rows = '0, req_cols = '0;
    logic [N-1:0][NAME_BYTES*8-1:0] req_name = '0;
    logic [N-1:0][DATA_W-1:0] req_data = '0;
    logic write_ready = 1'b0, write_done = 1'b0, writer_ready = 1'b0, clear_done = 1'b0;
    logic [N-1:0] grant, req_writer_ready, req_done, req_error;
    logic write_request, data_valid, clear_request;
    logic [MATRIX_ID_W-1:0] matrix_id, clear_matrix_id;
    logic [DIM_W-1:0] actual_rows, actual_cols;
    logic [NAME_BYTES*8-1:0] matrix_name;
    logic [DATA_W-1:0] data_in;
    int checks = 0;
    int passes = 0;

    matrix_storage_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_is_clear(req_is_clear), .req_matrix_id(req_matrix_id),
        .req_rows(req_rows), .req_cols(req_cols), .req_name(req_name),
        .req_data(req_data), .req_data_valid(req_data_valid),
        .grant(grant), .req_writer_ready(req_writer_ready), .req_done(req_done), .req_error(req_error),
        .write_request(write_request), .write_ready(write_ready), .matrix_id(matrix_id),
        .actual_rows(actual_rows), .actual_cols(actual_cols), .matrix_name(matrix_name),
        .data_in(data_in), .data_valid(data_valid), .write_done(write_done), .writer_ready(writer_ready),
        .clear_request(clear_request), .clear_done(clear_done), .clear_matrix_id(clear_matrix_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) passes++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, want);
    endtask

    task automatic enter_stream();
        write_ready = 1'b1;
        tick();
        write_ready = 1'b0;
    endtask

    task automatic complete(input logic [N-1:0] g, input bit drop);
        write_done = 1'b1;
        tick();
        write_done = 1'b0;
        check("done_pulse", req_done, g);
        if (drop) req_valid &= ~g;
        tick();
        check("grant_released", grant, 0);
    endtask

    initial begin
        logic [N-1:0] exp_g;
        writer_ready = 1'b1;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_done", {req_done, req_error}, 0);
        check("rst_wreq", {write_request, clear_request, data_valid}, 0);
        check("rst_name", matrix_name, 0);
        rst = 1'b0;

        req_valid = 4'b0001;
        req_matrix_id[0] = 3'd2;
        req_rows[0] = 8'd2;
        req_cols[0] = 8'd2;
        req_name[0] = "MATRIX_A";
        tick();
        check("w_grant", grant, 4'b0001);
        check("w_hdr", {matrix_id, actual_rows, actual_cols}, {3'd2, 8'd2, 8'd2});
        check("w_name", matrix_name, 64'h4D41_5452_4958_5F41);
        check("w_req_early", write_request, 0);
        write_ready = 1'b1;
        #1;
        check("w_req", write_request, 1);
        tick();
        write_ready = 1'b0;
        #1;
        check("w_req_once", write_request, 0);
        for (int i = 1; i <= 4; i++) begin
            req_data[0] = 32'(i);
            req_data_valid[0] = 1'b1;
            #1;
            check("w_beat", {data_valid, data_in}, {1'b1, 32'(i)});
            tick();
        end
        req_data_valid[0] = 1'b0;
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        check("w_stray_clear_done", {req_done, grant}, {4'b0000, 4'b0001});
        complete(4'b0001, 1'b1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_matrix_id[i] = 3'(i + 1);
            req_data[i] = 32'(32'hA0 + i);
        end
        req_valid = 4'b0111;
        req_data_valid = 4'b0111;
        tick();
        check("s_grant0", grant, 4'b0001);
        enter_stream();
        check("s_data0", {data_valid, data_in}, {1'b1, 32'hA0});
        check("s_wr_ready_owner", req_writer_ready, 4'b0001);
        req_data_valid[0] = 1'b0;
        #1;
        check("s_nonowner_dv", data_valid, 0);
        complete(4'b0001, 1'b1);
        tick();
        check("s_grant1", grant, 4'b0010);
        check("s_id1", matrix_id, 3'd2);
        enter_stream();
        check("s_data1", data_in, 32'hA1);
        complete(4'b0010, 1'b1);
        tick();
        check("s_grant2", grant, 4'b0100);
        enter_stream();
        complete(4'b0100, 1'b1);
        req_data_valid = '0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2) != 0 ? 4'b1000 : 4'b0010;
            tick();
            check("rr_grant", grant, exp_g);
            enter_stream();
            complete(exp_g, 1'b0);
        end
        req_valid = '0;

        req_valid = 4'b0100;
        req_is_clear[2] = 1'b1;
        req_matrix_id[2] = 3'd5;
        write_ready = 1'b1;
        tick();
        check("c_grant", grant, 4'b0100);
        check("c_not_yet", clear_request, 0);
        tick();
        check("c_req", {clear_request, clear_matrix_id}, {1'b1, 3'd5});
        check("c_no_wreq", write_request, 0);
        tick();
        check("c_req_once", clear_request, 0);
        write_ready = 1'b0;
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        check("c_done", {req_done, write_request}, {4'b0100, 1'b0});
        req_valid = '0;
        req_is_clear = '0;
        tick();
        check("c_idle", grant, 0);

        writer_ready = 1'b0;
        req_valid = 4'b0011;
        tick();
        check("t_grant", grant, 4'b0001);
        repeat (15) tick();
        check("t_not_yet", {req_error, req_done, grant}, {4'b0000, 4'b0000, 4'b0001});
        tick();
        check("t_error", {req_error, req_done}, {4'b0001, 4'b0000});
        req_valid = 4'b0010;
        writer_ready = 1'b1;
        tick();
        check("t_err_pulse", req_error, 0);
        tick();
        check("t_next_grant", grant, 4'b0010);
        enter_stream();
        complete(4'b0010, 1'b1);

        req_valid = 4'b1000;
        tick();
        check("r_grant3", grant, 4'b1000);
        enter_stream();
        req_data_valid[3] = 1'b1;
        #1;
        check("r_streaming", data_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_outputs", {grant, req_done, req_error, req_writer_ready, data_valid, matrix_id}, 0);
        check("r_name", matrix_name, 0);
        req_valid = 4'b1001;
        req_data_valid = '0;
        tick();
        check("r_restart", grant, 4'b0001);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/matrix_storage_arbiter.md
# matrix_storage_arbiter

Round-robin arbiter that shares the single write/clear port of the matrix storage manager among `NUM_REQ` requesters, such as the matrix input handler, the compute result writer and the random matrix generator. It grants one requester at a time and holds the grant for the whole transaction: a write request plus data stream, or a clear. It forwards that requester's control, header and data signals to the storage manager, returns completion to the requester, and aborts stalled transactions with a watchdog.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 65535: idle cycles without progress before the transaction is aborted.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i wants the port; held high until `req_done[i]`.
- `req_is_clear` in NUM_REQ: 1 = clear operation, 0 = write operation.
- `req_matrix_id` in NUM_REQ×3: target slot.
- `req_rows`, `req_cols` in NUM_REQ×8: dimensions, used for writes only.
- `req_name` in NUM_REQ×64: 8 ASCII bytes; byte 0 is in bits [63:56].
- `req_data` in NUM_REQ×32: write data.
- `req_data_valid` in NUM_REQ: write data strobe.
- `grant` out NUM_REQ: one-hot current owner.
- `req_writer_ready` out NUM_REQ: `writer_ready`, routed to the owner only.
- `req_done` out NUM_REQ: one-cycle completion pulse.
- `req_error` out NUM_REQ: one-cycle timeout pulse; it replaces `req_done`.
- `write_request` out 1, `write_ready` in 1, `matrix_id` out 3, `actual_rows` out 8, `actual_cols` out 8, `matrix_name` out 8×8, `data_in` out 32, `data_valid` out 1, `write_done` in 1, `writer_ready` in 1: storage manager write port.
- `clear_request` out 1, `clear_done` in 1, `clear_matrix_id` out 3: storage manager clear port.

## Operation
- **States**:
  - IDLE
  - ISSUE_WRITE
  - STREAM
  - ISSUE_CLEAR
  - WAIT_CLEAR
  - RELEASE
- **IDLE**:
  - If any `req_valid` is high, select the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Register `owner`, set `grant`, and latch the owner's header (id, rows, cols, name, is_clear) into holding registers.
  - Go to ISSUE_CLEAR if is_clear is set, otherwise ISSUE_WRITE.
- **ISSUE_WRITE**:
  - `write_request = write_ready`, combinationally.
  - When `write_ready` is high, go to STREAM.
- **STREAM**:
  - `data_in` and `data_valid` are muxed combinationally from the owner.
  - `req_writer_ready[owner] = writer_ready`; all other requesters see 0.
  - On `write_done`, go to RELEASE with status ok.
- **ISSUE_CLEAR**: `clear_request = 1` for exactly one cycle, then go to WAIT_CLEAR.
- **WAIT_CLEAR**: on `clear_done`, go to RELEASE with status ok.
- **RELEASE**:
  - Pulse `req_done[owner]`, or `req_error[owner]` if the status is timeout.
  - Clear `grant`.
  - Set `rr_ptr = owner+1`, wrapping at NUM_REQ.
  - Go to IDLE.
- **Header outputs**: `matrix_id`, `actual_rows`, `actual_cols`, `matrix_name` and `clear_matrix_id` come from the holding registers. They stay stable for the whole grant and hold their values in IDLE.
- **Watchdog**:
  - A 16-bit counter runs in ISSUE_WRITE, STREAM and WAIT_CLEAR.
  - It is cleared on state entry and on every `data_valid`, `write_ready` or `writer_ready` cycle.
  - When it reaches `TIMEOUT_CYCLES`, go to RELEASE with status timeout.
- **Boundary conditions**:
  - Non-owner `req_data_valid` is ignored.
  - If the owner drops `req_valid` mid-grant, that is ignored; the transaction still runs to completion or timeout.
  - A `write_done` or `clear_done` arriving outside its wait state is ignored.
  - The same requester cannot win twice in a row while another request is pending.

## Timing
- **Reset values**: every output is 0, `rr_ptr = 0`, state is IDLE, holding registers are 0. A reset mid-transaction aborts immediately and no `req_done` is issued.
- **Grant latency**: `req_valid` seen high in IDLE produces `grant` on the next cycle.
- **Clear latency**: `clear_request` occurs 2 cycles after `req_valid` is seen.
- **Release latency**: the `req_done` pulse appears the cycle after `write_done` or `clear_done`.
- **Re-arbitration**: the next grant comes no earlier than 2 cycles after `req_done`, because of RELEASE followed by IDLE.
- **Data path**: combinational from owner to storage manager with zero added latency. The owner's "data accepted" condition is `req_data_valid & req_writer_ready`.

## Structure
- **Shared package `matrix_pkg`**:
  - `arb_state_t` enum.
  - Constants `MATRIX_ID_W=3`, `DIM_W=8`, `NAME_BYTES=8`, `DATA_W=32`.
  - `matrix_hdr_t` struct: id, rows, cols, name.
- **Sub-module `rr_priority_select`**:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot winner, binary index, any.
  - Purely combinational; the rotate-and-priority-encode logic lives here.

## Test plan
- **Single write**: requester 0 writes id 2, 2×2, data 1,2,3,4. Expect one `write_request`, four `data_valid` beats carrying 1..4 with id 2, then `write_done` and `req_done[0]` one cycle later.
- **Simultaneous start**: requesters 0, 1 and 2 assert together at reset (`rr_ptr=0`). Expect grants in order 0, 1, 2; while 0 streams, `req_writer_ready[1]` and `req_writer_ready[2]` stay 0 and non-owner data is never forwarded.
- **Round-robin fairness**: requesters 1 and 3 are both permanently pending. Expect grants alternating 1, 3, 1, 3; requester 1 never wins twice in a row.
- **Clear**: requester 2 clears id 5. Expect `clear_request` high for exactly 1 cycle with `clear_matrix_id=5`; after `clear_done`, expect `req_done[2]` and no `write_request`.
- **Timeout**: with `TIMEOUT_CYCLES=16`, `write_ready` is held low. Expect `req_error[owner]` after 16 stalled cycles, no `req_done`, and the next requester granted.
- **Reset mid-stream**: assert `rst` during STREAM. Expect all outputs 0 on the next cycle, `grant=0`, and arbitration restarting from requester 0.
